id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
//  Decode stage plus ID/EX pipeline register. It sits between the IF/ID register and EX.
//  It drives the register-file read selects from the instruction and bypasses a same-cycle
//  WB write into the operands. It decodes control, detects load-use hazards (stall + bubble)
//  and registers everything for EX.
// PARAMETERS
//  DATA_W   32  datapath / register width
//  ADDR_W    5  register address width
// PORTS
//  clk              in   1       rising-edge clock
//  rst              in   1       synchronous, active-high reset
//  if_id_valid      in   1       IF/ID holds a real instruction
//  if_id_instr      in   32      instruction word from IF/ID
//  if_id_pc         in   32      PC+4 of that instruction
//  flush            in   1       branch-taken squash from EX/MEM
//  read_sel_1       out  ADDR_W  = instr[25:21] (rs), combinational
//  read_sel_2       out  ADDR_W  = instr[20:16] (rt), combinational
//  read_data_1      in   DATA_W  register-file port 1 (combinational read)
//  read_data_2      in   DATA_W  register-file port 2
//  wb_reg_write     in   1       WB writes the register file this cycle
//  wb_write_address in   ADDR_W  WB destination
//  wb_write_data    in   DATA_W  WB data
//  stall            out  1       hold PC and IF/ID this cycle (combinational)
//  ex_valid         out  1       EX holds a real instruction
//  ex_pc            out  32     registered PC+4
//  ex_rs_data       out  DATA_W  registered operand A (after bypass)
//  ex_rt_data       out  DATA_W  registered operand B (after bypass)
//  ex_imm           out  DATA_W  sign-extended instr[15:0]
//  ex_rs, ex_rt     out  ADDR_W  registered source addresses (for forwarding unit)
//  ex_rd            out  ADDR_W  destination: rd (R-type) else rt
//  ex_reg_write     out  1       \
//  ex_mem_read      out  1        |
//  ex_mem_write     out  1        | registered control
//  ex_branch        out  1        |
//  ex_alu_src       out  1        | 1 = imm
//  ex_alu_op        out  2       / 00 add, 01 sub, 10 funct-decoded
// BEHAVIOUR
//  Decode (opcode instr[31:26]):
//   - 0x00 R-type: reg_write, alu_op=10, rd=instr[15:11].
//   - 0x23 lw: reg_write, mem_read, alu_src, alu_op=00.
//   - 0x2B sw: mem_write, alu_src, alu_op=00.
//   - 0x04 beq: branch, alu_op=01.
//   - 0x08 addi: reg_write, alu_src, alu_op=00.
//   - Any other opcode: all control 0 (NOP); ex_valid still follows if_id_valid.
//   - reg_write is forced 0 when the destination is r0.
//  Bypass: if wb_reg_write && wb_write_address!=0 && wb_write_address==rs, operand A takes
//   wb_write_data instead of read_data_1. Operand B likewise with rt. This covers the
//   write-then-read hazard of the posedge-write register file.
//  Load-use hazard (combinational): stall=1 when all of the following hold:
//   - ex_valid && ex_mem_read && ex_rd!=0 && if_id_valid && !flush;
//   - ex_rd==rs, or ex_rd==rt with opcode in {R-type, sw, beq}.
//  Register update each posedge (priority order):
//   1. rst: every ex_* output = 0 (ex_valid=0, all control 0, data/addr 0).
//   2. flush: bubble. ex_valid and all control = 0; data fields don't-care (cleared to 0).
//   3. stall: bubble, identical to flush. IF/ID is held by upstream, so the instruction
//      re-decodes next cycle.
//   4. else: load the decoded values; ex_valid <= if_id_valid. When !if_id_valid, control is 0.
//  Latency: 1 cycle from IF/ID to EX outputs. stall lasts exactly 1 cycle per load-use pair,
//   because the bubble clears ex_mem_read.
//  flush and stall together: flush wins; stall is output 0.
//  Reset mid-stall: bubble; stall drops the next cycle because ex_valid=0.
//  No handshake other than stall; stall has no registered state.
// TESTING (regfile preloaded rN = 10*N)
//  1. Reset: assert rst 2 cycles with a valid add in IF/ID -> all ex_* = 0, stall=0.
//  2. add r1,r2,r3 -> next cycle ex_rs_data=20, ex_rt_data=30, ex_rd=1, ex_reg_write=1,
//     ex_alu_op=10.
//  3. Bypass: decode add r4,r5,r6 while WB writes r5=0x55 -> ex_rs_data=0x55, ex_rt_data=60.
//     Repeat with wb address 0 -> ex_rs_data=50.
//  4. Load-use: lw r7,4(r1) then add r8,r7,r2:
//     - add in ID -> stall=1 for 1 cycle; next ex_valid=0 with all control 0;
//     - following cycle the add loads, stall=0.
//  5. Flush vs stall: repeat scenario 4 with flush=1 in the hazard cycle -> stall=0, bubble
//     inserted; addi r0,r1,5 -> ex_reg_write=0.
//  6. sw r9,8(r2) after lw r9 -> stall=1. lw r9 then addi r10,r3,1 (rt mismatch) -> stall=0,
//     imm=0x00000001. Imm 0x8000 -> ex_imm=0xFFFF8000.

Source files
------------

// File: rtl/id_ex_stage_if.sv
// Signal bundle between the IF/ID register, register file, WB stage and the ID/EX register.
// The stage uses the slave modport; the surrounding pipeline (or a bench) uses master.
interface id_ex_stage_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              if_id_valid;
  logic [31:0]       if_id_instr;
  logic [31:0]       if_id_pc;
  logic              flush;
  logic [ADDR_W-1:0] read_sel_1;
  logic [ADDR_W-1:0] read_sel_2;
  logic [DATA_W-1:0] read_data_1;
  logic [DATA_W-1:0] read_data_2;
  logic              wb_reg_write;
  logic [ADDR_W-1:0] wb_write_address;
  logic [DATA_W-1:0] wb_write_data;
  logic              stall;
  logic              ex_valid;
  logic [31:0]       ex_pc;
  logic [DATA_W-1:0] ex_rs_data;
  logic [DATA_W-1:0] ex_rt_data;
  logic [DATA_W-1:0] ex_imm;
  logic [ADDR_W-1:0] ex_rs;
  logic [ADDR_W-1:0] ex_rt;
  logic [ADDR_W-1:0] ex_rd;
  logic              ex_reg_write;
  logic              ex_mem_read;
  logic              ex_mem_write;
  logic              ex_branch;
  logic              ex_alu_src;
  logic [1:0]        ex_alu_op;

  modport slave (
    input  if_id_valid, if_id_instr, if_id_pc, flush, read_data_1, read_data_2,
           wb_reg_write, wb_write_address, wb_write_data,
    output read_sel_1, read_sel_2, stall, ex_valid, ex_pc, ex_rs_data, ex_rt_data, ex_imm,
           ex_rs, ex_rt, ex_rd, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch,
           ex_alu_src, ex_alu_op
  );

  modport master (
    output if_id_valid, if_id_instr, if_id_pc, flush, read_data_1, read_data_2,
           wb_reg_write, wb_write_address, wb_write_data,
    input  read_sel_1, read_sel_2, stall, ex_valid, ex_pc, ex_rs_data, ex_rt_data, ex_imm,
           ex_rs, ex_rt, ex_rd, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch,
           ex_alu_src, ex_alu_op
  );
endinterface

// File: rtl/id_ex_stage.sv
// Decode stage with WB bypass, load-use hazard detection and the ID/EX pipeline register.
// A hazard or flush turns the slot into a bubble; IF/ID is held upstream while stall is high.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input logic           clk,
  input logic           rst,
  id_ex_stage_if.slave  bus
);
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  typedef struct packed {
    logic              valid;
    logic [31:0]       pc;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] imm;
    logic [ADDR_W-1:0] rs;
    logic [ADDR_W-1:0] rt;
    logic [ADDR_W-1:0] rd;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              branch;
    logic              alu_src;
    logic [1:0]        alu_op;
  } ex_bundle_t;

  localparam ex_bundle_t EX_BUBBLE = {$bits(ex_bundle_t){1'b0}};
  localparam logic [ADDR_W-1:0] REG_ZERO = {ADDR_W{1'b0}};

  logic [5:0]        opcode_s;
  logic [ADDR_W-1:0] rs_s;
  logic [ADDR_W-1:0] rt_s;
  logic [ADDR_W-1:0] rd_field_s;
  logic [ADDR_W-1:0] dest_s;
  logic              reg_write_s;
  logic              mem_read_s;
  logic              mem_write_s;
  logic              branch_s;
  logic              alu_src_s;
  logic              uses_rt_s;
  logic [1:0]        alu_op_s;
  logic [DATA_W-1:0] op_a_s;
  logic [DATA_W-1:0] op_b_s;
  logic              stall_s;
  ex_bundle_t        decoded_s;
  ex_bundle_t        next_s;
  ex_bundle_t        ex_r;

  assign opcode_s      = bus.if_id_instr[31:26];
  assign rs_s          = ADDR_W'(bus.if_id_instr[25:21]);
  assign rt_s          = ADDR_W'(bus.if_id_instr[20:16]);
  assign rd_field_s    = ADDR_W'(bus.if_id_instr[15:11]);
  assign bus.read_sel_1 = rs_s;
  assign bus.read_sel_2 = rt_s;

  // Opcode decode into raw control, destination and whether rt is read as a source.
  always_comb begin
    reg_write_s = 1'b0;
    mem_read_s  = 1'b0;
    mem_write_s = 1'b0;
    branch_s    = 1'b0;
    alu_src_s   = 1'b0;
    alu_op_s    = 2'b00;
    dest_s      = rt_s;
    uses_rt_s   = 1'b0;
    case (opcode_s)
      OP_RTYPE: begin reg_write_s = 1'b1; alu_op_s = 2'b10; dest_s = rd_field_s; uses_rt_s = 1'b1; end
      OP_LW:    begin reg_write_s = 1'b1; mem_read_s = 1'b1; alu_src_s = 1'b1; end
      OP_SW:    begin mem_write_s = 1'b1; alu_src_s = 1'b1; uses_rt_s = 1'b1; end
      OP_BEQ:   begin branch_s = 1'b1; alu_op_s = 2'b01; uses_rt_s = 1'b1; end
      OP_ADDI:  begin reg_write_s = 1'b1; alu_src_s = 1'b1; end
      default:  begin reg_write_s = 1'b0; end
    endcase
  end

  // Operand selection: a WB write landing this cycle overrides the stale register-file read.
  always_comb begin
    op_a_s = bus.read_data_1;
    op_b_s = bus.read_data_2;
    if (bus.wb_reg_write && (bus.wb_write_address != REG_ZERO) && (bus.wb_write_address == rs_s)) begin
      op_a_s = bus.wb_write_data;
    end else begin
      op_a_s = bus.read_data_1;
    end
    if (bus.wb_reg_write && (bus.wb_write_address != REG_ZERO) && (bus.wb_write_address == rt_s)) begin
      op_b_s = bus.wb_write_data;
    end else begin
      op_b_s = bus.read_data_2;
    end
  end

  assign stall_s = ex_r.valid && ex_r.mem_read && (ex_r.rd != REG_ZERO) &&
                   bus.if_id_valid && !bus.flush &&
                   ((ex_r.rd == rs_s) || (uses_rt_s && (ex_r.rd == rt_s)));
  assign bus.stall = stall_s;

  // Assemble the ID/EX payload; flush outranks stall, both produce a bubble.
  always_comb begin
    decoded_s         = EX_BUBBLE;
    decoded_s.valid   = bus.if_id_valid;
    decoded_s.pc      = bus.if_id_pc;
    decoded_s.rs_data = op_a_s;
    decoded_s.rt_data = op_b_s;
    decoded_s.imm     = {{(DATA_W-16){bus.if_id_instr[15]}}, bus.if_id_instr[15:0]};
    decoded_s.rs      = rs_s;
    decoded_s.rt      = rt_s;
    decoded_s.rd      = dest_s;
    if (bus.if_id_valid) begin
      decoded_s.reg_write = reg_write_s && (dest_s != REG_ZERO);
      decoded_s.mem_read  = mem_read_s;
      decoded_s.mem_write = mem_write_s;
      decoded_s.branch    = branch_s;
      decoded_s.alu_src   = alu_src_s;
      decoded_s.alu_op    = alu_op_s;
    end else begin
      decoded_s.reg_write = 1'b0;
      decoded_s.mem_read  = 1'b0;
      decoded_s.mem_write = 1'b0;
      decoded_s.branch    = 1'b0;
      decoded_s.alu_src   = 1'b0;
      decoded_s.alu_op    = 2'b00;
    end
    if (bus.flush || stall_s) begin
      next_s = EX_BUBBLE;
    end else begin
      next_s = decoded_s;
    end
  end

  // ID/EX pipeline register.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_r <= EX_BUBBLE;
    end else begin
      ex_r <= next_s;
    end
  end

  assign bus.ex_valid     = ex_r.valid;
  assign bus.ex_pc        = ex_r.pc;
  assign bus.ex_rs_data   = ex_r.rs_data;
  assign bus.ex_rt_data   = ex_r.rt_data;
  assign bus.ex_imm       = ex_r.imm;
  assign bus.ex_rs        = ex_r.rs;
  assign bus.ex_rt        = ex_r.rt;
  assign bus.ex_rd        = ex_r.rd;
  assign bus.ex_reg_write = ex_r.reg_write;
  assign bus.ex_mem_read  = ex_r.mem_read;
  assign bus.ex_mem_write = ex_r.mem_write;
  assign bus.ex_branch    = ex_r.branch;
  assign bus.ex_alu_src   = ex_r.alu_src;
  assign bus.ex_alu_op    = ex_r.alu_op;
endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: instructions are generated by kind, the expected EX
// contents are queued at issue time and a negedge monitor pops them when ex_valid is seen.
module tb_id_ex_stage;
  typedef enum logic [2:0] {K_ADD, K_LW, K_SW, K_BEQ, K_ADDI, K_OTHER} kind_e;
  typedef struct packed {
    kind_e      kind;
    logic [5:0] xop;
    logic [4:0] rs, rt, rd;
    logic [15:0] imm;
  } ins_t;
  typedef struct packed {
    logic [31:0] pc, a, b, imm;
    logic [4:0]  rs, rt, rd;
    logic [6:0]  ctrl;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          checks = 0;
  int          failures = 0;
  logic [31:0] rf [32];
  exp_t        exp_q[$];
  logic        prev_load = 1'b0;
  logic [4:0]  prev_dest = 5'd0;
  logic [31:0] pc_ctr = 32'h0000_1000;
  logic [6:0]  ctrl_act;

  id_ex_stage_if #(.DATA_W(32), .ADDR_W(5)) bus_if ();
  id_ex_stage #(.DATA_W(32), .ADDR_W(5)) dut (.clk(clk), .rst(rst), .bus(bus_if));

  always #5 clk = ~clk;

  assign bus_if.read_data_1 = rf[bus_if.read_sel_1];
  assign bus_if.read_data_2 = rf[bus_if.read_sel_2];
  assign ctrl_act = {bus_if.ex_reg_write, bus_if.ex_mem_read, bus_if.ex_mem_write,
                     bus_if.ex_branch, bus_if.ex_alu_src, bus_if.ex_alu_op};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic ins_t mk(kind_e k, logic [4:0] rs, logic [4:0] rt, logic [4:0] rd, logic [15:0] imm);
    ins_t i;
    i.kind = k; i.xop = 6'h0D; i.rs = rs; i.rt = rt; i.rd = rd; i.imm = imm;
    return i;
  endfunction

  function automatic logic [15:0] low16(ins_t i);
    return (i.kind == K_ADD) ? {i.rd, 5'd0, 6'h20} : i.imm;
  endfunction

  function automatic logic [31:0] encode(ins_t i);
    case (i.kind)
      K_ADD:   return {6'h00, i.rs, i.rt, low16(i)};
      K_LW:    return {6'h23, i.rs, i.rt, i.imm};
      K_SW:    return {6'h2B, i.rs, i.rt, i.imm};
      K_BEQ:   return {6'h04, i.rs, i.rt, i.imm};
      K_ADDI:  return {6'h08, i.rs, i.rt, i.imm};
      default: return {i.xop, i.rs, i.rt, i.imm};
    endcase
  endfunction

  function automatic logic [4:0] dest_of(ins_t i);
    return (i.kind == K_ADD) ? i.rd : i.rt;
  endfunction

  // {reg_write, mem_read, mem_write, branch, alu_src, alu_op}
  function automatic logic [6:0] ctrl_of(ins_t i);
    logic [6:0] c;
    case (i.kind)
      K_ADD:   c = 7'b10000_10;
      K_LW:    c = 7'b11001_00;
      K_SW:    c = 7'b00101_00;
      K_BEQ:   c = 7'b00010_01;
      K_ADDI:  c = 7'b10001_00;
      default: c = 7'b00000_00;
    endcase
    if (dest_of(i) == 5'd0) c[6] = 1'b0;
    return c;
  endfunction

  task automatic step(input ins_t i, input logic valid, input logic fl, input logic wbw,
                      input logic [4:0] wba, input logic [31:0] wbd, output logic stalled);
    exp_t e;
    logic exp_stall;
    logic uses_rt;
    logic [15:0] lo;
    uses_rt = (i.kind == K_ADD) || (i.kind == K_SW) || (i.kind == K_BEQ);
    @(negedge clk);
    bus_if.if_id_valid      = valid;
    bus_if.if_id_instr      = encode(i);
    bus_if.if_id_pc         = pc_ctr;
    bus_if.flush            = fl;
    bus_if.wb_reg_write     = wbw;
    bus_if.wb_write_address = wba;
    bus_if.wb_write_data    = wbd;
    #1;
    exp_stall = prev_load && valid && !fl &&
                ((prev_dest == i.rs) || (uses_rt && (prev_dest == i.rt)));
    chk("stall", 32'(bus_if.stall), 32'(exp_stall));
    stalled = exp_stall;
    if (fl || exp_stall || !valid) begin
      prev_load = 1'b0;
    end else begin
      lo     = low16(i);
      e.pc   = pc_ctr;
      e.a    = (wbw && wba != 5'd0 && wba == i.rs) ? wbd : rf[i.rs];
      e.b    = (wbw && wba != 5'd0 && wba == i.rt) ? wbd : rf[i.rt];
      e.imm  = {{16{lo[15]}}, lo};
      e.rs   = i.rs;
      e.rt   = i.rt;
      e.rd   = dest_of(i);
      e.ctrl = ctrl_of(i);
      exp_q.push_back(e);
      prev_load = (i.kind == K_LW) && (dest_of(i) != 5'd0);
      prev_dest = dest_of(i);
    end
    @(posedge clk);
    #1;
    if (wbw && wba != 5'd0) rf[wba] = wbd;
  endtask

  task automatic issue(input ins_t i, input logic fl, input logic wbw,
                       input logic [4:0] wba, input logic [31:0] wbd);
    logic st;
    step(i, 1'b1, fl, wbw, wba, wbd, st);
    if (st) step(i, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, st);
    pc_ctr += 32'd4;
  endtask

  // Monitor: every EX slot is either a queued instruction or a control-free bubble.
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst) begin
      if (bus_if.ex_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_ex: ex_valid=1 pc=%h with nothing expected", bus_if.ex_pc);
        end else begin
          e = exp_q.pop_front();
          chk("ex_pc", bus_if.ex_pc, e.pc);
          chk("ex_rs_data", bus_if.ex_rs_data, e.a);
          chk("ex_rt_data", bus_if.ex_rt_data, e.b);
          chk("ex_imm", bus_if.ex_imm, e.imm);
          chk("ex_rs", 32'(bus_if.ex_rs), 32'(e.rs));
          chk("ex_rt", 32'(bus_if.ex_rt), 32'(e.rt));
          chk("ex_rd", 32'(bus_if.ex_rd), 32'(e.rd));
          chk("ex_ctrl", 32'(ctrl_act), 32'(e.ctrl));
        end
      end else begin
        chk("bubble_ctrl", 32'(ctrl_act), 32'd0);
      end
    end
  end

  initial begin
    ins_t ri;
    logic st, v, fl, wbw;
    logic [4:0] wba;
    for (int r = 0; r < 32; r++) rf[r] = 32'(r * 10);
    bus_if.flush = 1'b0;
    bus_if.wb_reg_write = 1'b0;
    bus_if.wb_write_address = 5'd0;
    bus_if.wb_write_data = 32'd0;
    bus_if.if_id_valid = 1'b1;
    bus_if.if_id_instr = encode(mk(K_ADD, 5'd2, 5'd3, 5'd1, 16'd0));
    bus_if.if_id_pc = pc_ctr;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ex_valid", 32'(bus_if.ex_valid), 32'd0);
    chk("rst_ctrl", 32'(ctrl_act), 32'd0);
    chk("rst_data", bus_if.ex_pc | bus_if.ex_rs_data | bus_if.ex_rt_data | bus_if.ex_imm, 32'd0);
    chk("rst_addr", 32'({bus_if.ex_rs, bus_if.ex_rt, bus_if.ex_rd}), 32'd0);
    chk("rst_stall", 32'(bus_if.stall), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bus_if.if_id_valid = 1'b0;

    issue(mk(K_ADD, 5'd2, 5'd3, 5'd1, 16'd0), 1'b0, 1'b0, 5'd0, 32'd0);
    issue(mk(K_ADD, 5'd5, 5'd6, 5'd4, 16'd0), 1'b0, 1'b1, 5'd0, 32'h55);
    issue(mk(K_ADD, 5'd5, 5'd6, 5'd4, 16'd0), 1'b0, 1'b1, 5'd5, 32'h55);
    issue(mk(K_LW, 5'd1, 5'd7, 5'd0, 16'd4), 1'b0, 1'b0, 5'd0, 32'd0);
    issue(mk(K_ADD, 5'd7, 5'd2, 5'd8, 16'd0), 1'b0, 1'b0, 5'd0, 32'd0);
    issue(mk(K_LW, 5'd1, 5'd7, 5'd0, 16'd4), 1'b0, 1'b0, 5'd0, 32'd0);
    issue(mk(K_ADD, 5'd7, 5'd2, 5'd8, 16'd0), 1'b1, 1'b0, 5'd0, 32'd0);
    issue(mk(K_ADDI, 5'd1, 5'd0, 5'd0, 16'd5), 1'b0, 1'b0, 5'd0, 32'd0);
    issue(mk(K_LW, 5'd1, 5'd9, 5'd0, 16'd0), 1'b0, 1'b0, 5'd0, 32'd0);
    issue(mk(K_SW, 5'd2, 5'd9, 5'd0, 16'd8), 1'b0, 1'b0, 5'd0, 32'd0);
    issue(mk(K_LW, 5'd1, 5'd9, 5'd0, 16'd0), 1'b0, 1'b0, 5'd0, 32'd0);
    issue(mk(K_ADDI, 5'd3, 5'd10, 5'd0, 16'd1), 1'b0, 1'b0, 5'd0, 32'd0);
    issue(mk(K_ADDI, 5'd1, 5'd11, 5'd0, 16'h8000), 1'b0, 1'b0, 5'd0, 32'd0);
    issue(mk(K_BEQ, 5'd11, 5'd4, 5'd0, 16'hFFFC), 1'b0, 1'b0, 5'd0, 32'd0);

    // Small register range keeps load-use and bypass collisions frequent.
    for (int n = 0; n < 400; n++) begin
      ri = mk(kind_e'($urandom_range(0, 5)), 5'($urandom_range(0, 7)),
              5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom));
      case ($urandom_range(0, 2))
        0:       ri.xop = 6'h0D;
        1:       ri.xop = 6'h02;
        default: ri.xop = 6'h3F;
      endcase
      v   = ($urandom_range(0, 9) != 0);
      fl  = ($urandom_range(0, 9) == 0);
      wbw = ($urandom_range(0, 2) == 0);
      wba = 5'($urandom_range(0, 7));
      step(ri, v, fl, wbw, wba, $urandom, st);
      if (st) step(ri, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, st);
      pc_ctr += 32'd4;
    end

    repeat (2) step(mk(K_OTHER, 5'd0, 5'd0, 5'd0, 16'd0), 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, st);
    @(negedge clk);
    #1;
    chk("drain", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
